// File: rtl/x_top_uart_tx_arb.sv
// Two-requester arbiter in front of a UART transmitter.
// Round-robin grant per message, grant held until the last byte or an
// idle timeout; no byte storage, the granted requester is muxed straight
// through to the downstream interface.
module x_top_uart_tx_arb #(
  parameter int p_timeout = 1024
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_a_valid,
  input  logic [7:0] i_a_data,
  input  logic       i_a_last,
  output logic       o_a_accept,
  input  logic       i_b_valid,
  input  logic [7:0] i_b_data,
  input  logic       i_b_last,
  output logic       o_b_accept,
  output logic       o_valid,
  output logic [7:0] o_data,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  localparam int unsigned CW = $clog2(p_timeout) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(p_timeout - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_A = 2'b01,
    GNT_B = 2'b10
  } state_t;

  state_t        state;
  logic          ptr_b;      // 0: A wins a tie, 1: B wins a tie
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          sel_valid;
  logic          sel_last;
  logic          xfer;
  logic          timeout_hit;

  // Select the granted requester and derive transfer / timeout conditions.
  always_comb begin
    sel_valid  = 1'b0;
    sel_last   = 1'b0;
    o_valid    = 1'b0;
    o_data     = '0;
    o_a_accept = 1'b0;
    o_b_accept = 1'b0;
    unique case (state)
      GNT_A: begin
        sel_valid  = i_a_valid;
        sel_last   = i_a_last;
        o_valid    = i_a_valid;
        o_data     = i_a_data;
        o_a_accept = i_accept;
      end
      GNT_B: begin
        sel_valid  = i_b_valid;
        sel_last   = i_b_last;
        o_valid    = i_b_valid;
        o_data     = i_b_data;
        o_b_accept = i_accept;
      end
      default: ;
    endcase
    xfer    = sel_valid && i_accept;
    cnt_inc = cnt + 1'b1;
    // Release on the edge where the counter would reach p_timeout-1, so a
    // grant survives exactly p_timeout-1 idle cycles.
    timeout_hit = (state != IDLE) && !sel_valid && (cnt_inc == TO_LAST);
    o_grant = state;
  end

  // Grant state, round-robin pointer and idle timeout counter.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state <= IDLE;
      ptr_b <= 1'b0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (i_a_valid && (!i_b_valid || !ptr_b)) state <= GNT_A;
          else if (i_b_valid)                      state <= GNT_B;
        end
        GNT_A, GNT_B: begin
          if (xfer) begin
            cnt <= '0;
            if (sel_last) begin
              state <= IDLE;
              ptr_b <= (state == GNT_A);
            end
          end else if (timeout_hit) begin
            state <= IDLE;
            ptr_b <= (state == GNT_A);
            cnt   <= '0;
          end else if (!sel_valid) begin
            cnt <= cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_x_top_uart_tx_arb.sv
// Bench for x_top_uart_tx_arb: directed scenarios with literal
// expectations, then randomized traffic, all outputs compared every
// cycle against a message-level ownership model.
module tb_x_top_uart_tx_arb;

  localparam int P = 8;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       a_valid = 1'b0, a_last = 1'b0, a_acc;
  logic [7:0] a_data = 8'h00;
  logic       b_valid = 1'b0, b_last = 1'b0, b_acc;
  logic [7:0] b_data = 8'h00;
  logic       o_valid, acc = 1'b0;
  logic [7:0] o_data;
  logic [1:0] o_grant;

  int total = 0;
  int bad   = 0;

  x_top_uart_tx_arb #(.p_timeout(P)) dut (
    .i_clk(clk), .i_nrst(nrst),
    .i_a_valid(a_valid), .i_a_data(a_data), .i_a_last(a_last), .o_a_accept(a_acc),
    .i_b_valid(b_valid), .i_b_data(b_data), .i_b_last(b_last), .o_b_accept(b_acc),
    .o_valid(o_valid), .o_data(o_data), .i_accept(acc), .o_grant(o_grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: who owns the current message (0 none, 1 A, 2 B),
  // whose turn a tie is, and how many idle cycles the owner has spent.
  int m_owner = 0, m_turn = 0, m_idle = 0;
  bit m_xa = 0, m_xb = 0;

  always @(posedge clk or negedge nrst) begin
    int ow, tu, id;
    bit v, l, xa, xb;
    if (!nrst) begin
      m_owner <= 0; m_turn <= 0; m_idle <= 0; m_xa <= 0; m_xb <= 0;
    end else begin
      ow = m_owner; tu = m_turn; id = m_idle; xa = 0; xb = 0;
      if (ow == 0) begin
        if (a_valid && b_valid) ow = (tu == 0) ? 1 : 2;
        else if (a_valid)       ow = 1;
        else if (b_valid)       ow = 2;
        id = 0;
      end else begin
        v = (ow == 1) ? a_valid : b_valid;
        l = (ow == 1) ? a_last  : b_last;
        if (v && acc) begin
          id = 0;
          if (ow == 1) xa = 1; else xb = 1;
          if (l) begin tu = (ow == 1) ? 1 : 0; ow = 0; end
        end else if (!v) begin
          id = id + 1;
          if (id == P - 1) begin tu = (ow == 1) ? 1 : 0; ow = 0; id = 0; end
        end
      end
      m_owner <= ow; m_turn <= tu; m_idle <= id; m_xa <= xa; m_xb <= xb;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [1:0] eg;
    logic       ev, eaa, eba;
    logic [7:0] ed;
    eg = 2'b00; ev = 1'b0; ed = 8'h00; eaa = 1'b0; eba = 1'b0;
    if (nrst && m_owner == 1) begin
      eg = 2'b01; ev = a_valid; ed = a_data; eaa = acc;
    end else if (nrst && m_owner == 2) begin
      eg = 2'b10; ev = b_valid; ed = b_data; eba = acc;
    end
    chk("m_grant", {6'd0, o_grant}, {6'd0, eg});
    chk("m_valid", {7'd0, o_valid}, {7'd0, ev});
    chk("m_data", o_data, ed);
    chk("m_a_acc", {7'd0, a_acc}, {7'd0, eaa});
    chk("m_b_acc", {7'd0, b_acc}, {7'd0, eba});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int a_pause = 0, b_pause = 0;

  initial begin
    // reset with both requesters asking
    a_valid = 1; a_data = 8'h11; b_valid = 1; b_data = 8'h99; b_last = 1;
    acc = 1;
    #3;
    chk("rst_grant", {6'd0, o_grant}, 8'h00);
    chk("rst_valid", {7'd0, o_valid}, 8'h00);
    chk("rst_acc", {6'd0, a_acc, b_acc}, 8'h00);
    tick(); tick();
    nrst = 1;
    tick();
    #2 chk("rel_grant", {6'd0, o_grant}, 8'h01);
    chk("a_byte1", o_data, 8'h11);
    chk("b_locked1", {7'd0, b_acc}, 8'h00);
    // A's three-byte message with B waiting
    tick(); a_data = 8'h22;
    #2 chk("a_byte2", o_data, 8'h22);
    chk("a_grant2", {6'd0, o_grant}, 8'h01);
    chk("b_locked2", {7'd0, b_acc}, 8'h00);
    tick(); a_data = 8'h33; a_last = 1;
    #2 chk("a_byte3", o_data, 8'h33);
    tick(); a_valid = 0; a_last = 0;
    #2 chk("a_end_idle", {6'd0, o_grant}, 8'h00);
    tick();
    #2 chk("b_after_a", {6'd0, o_grant}, 8'h10 >> 3);
    chk("b_data", o_data, 8'h99);
    // timeout: A sends one non-last byte, then goes quiet
    tick(); b_valid = 0; a_valid = 1; a_data = 8'h55; a_last = 0;
    tick();
    #2 chk("to_grant", {6'd0, o_grant}, 8'h01);
    tick(); a_valid = 0; b_valid = 1; b_data = 8'hB0;
    for (int i = 0; i < P - 2; i++) begin
      tick();
      #2 chk("to_held", {6'd0, o_grant}, 8'h01);
      chk("to_novalid", {7'd0, o_valid}, 8'h00);
    end
    tick();
    #2 chk("to_release", {6'd0, o_grant}, 8'h00);
    tick();
    #2 chk("to_b_next", {6'd0, o_grant}, 8'h02);
    // busy hold: downstream not ready for 20 cycles
    tick(); b_valid = 0; a_valid = 1; a_data = 8'h77; a_last = 1; acc = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      #2 chk("busy_grant", {6'd0, o_grant}, 8'h01);
    end
    acc = 1;
    #2 chk("busy_data", o_data, 8'h77);
    chk("busy_acc", {7'd0, a_acc}, 8'h01);
    tick(); a_valid = 0;
    #2 chk("busy_done", {6'd0, o_grant}, 8'h00);
    // round robin with both sending one-byte messages (B's turn after A)
    a_valid = 1; a_last = 1; b_valid = 1; b_last = 1;
    tick(); #2 chk("rr0", {6'd0, o_grant}, 8'h02);
    tick(); #2 chk("rr1", {6'd0, o_grant}, 8'h00);
    tick(); #2 chk("rr2", {6'd0, o_grant}, 8'h01);
    tick(); #2 chk("rr3", {6'd0, o_grant}, 8'h00);
    tick(); #2 chk("rr4", {6'd0, o_grant}, 8'h02);
    // reset mid-message: pointer returns to A
    b_valid = 0; a_last = 0;
    tick(); tick(); tick();
    #1 nrst = 0;
    #1 chk("midrst_grant", {6'd0, o_grant}, 8'h00);
    b_valid = 1;
    tick(); nrst = 1;
    tick();
    #2 chk("midrst_rearb", {6'd0, o_grant}, 8'h01);
    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (m_xa) begin a_data = 8'($urandom); a_last = ($urandom_range(0, 3) == 0); end
      if (m_xb) begin b_data = 8'($urandom); b_last = ($urandom_range(0, 3) == 0); end
      if (a_pause > 0) begin a_pause--; a_valid = 0; end
      else if ($urandom_range(0, 15) == 0) begin a_pause = $urandom_range(1, 12); a_valid = 0; end
      else a_valid = 1;
      if (b_pause > 0) begin b_pause--; b_valid = 0; end
      else if ($urandom_range(0, 15) == 0) begin b_pause = $urandom_range(1, 12); b_valid = 0; end
      else b_valid = 1;
      acc = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 999) == 0) begin
        #1 nrst = 0;
        #2 nrst = 1;
      end
    end
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
